mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, memory word-address width.
REQ-002 Parameter DATA_WIDTH, default 32, memory word width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a transfer; sampled only in IDLE.
REQ-006 src_addr  input  ADDR_WIDTH  first source word address, sampled with start.
REQ-007 dst_addr  input  ADDR_WIDTH  first destination word address, sampled with start.
REQ-008 length  input  ADDR_WIDTH+1  word count 0..2**ADDR_WIDTH, sampled with start.
REQ-009 busy  output  1  high from the cycle after start acceptance until the DONE cycle inclusive.
REQ-010 done  output  1  one-cycle pulse marking transfer completion.
REQ-011 mem_address  output  ADDR_WIDTH  word address to the RAM.
REQ-012 mem_wdata  output  DATA_WIDTH  write data to the RAM.
REQ-013 mem_write  output  1  RAM write enable, written at posedge clk.
REQ-014 mem_rdata  input  DATA_WIDTH  RAM asynchronous read data for mem_address, same cycle.

Function
REQ-015 FSM states IDLE, READ, WRITE, DONE; state is a register.
REQ-016 IDLE: start=1 and length>0 -> latch src/dst/length, go READ; start=1 and length=0 -> go DONE, no RAM writes; else stay.
REQ-017 READ: drive mem_address=src pointer, mem_write=0; capture mem_rdata into data buffer at the clock edge; go WRITE.
REQ-018 WRITE: drive mem_address=dst pointer, mem_wdata=buffer, mem_write=1; increment both pointers and decrement remaining count; go READ if remaining>1, else DONE.
REQ-019 DONE: done=1 for exactly one cycle, busy=1; go IDLE.
REQ-020 Copy latency: for length N>0, done is high exactly 2N+1 cycles after the start-accept edge; exactly N mem_write cycles occur.
REQ-021 Pointers increment modulo 2**ADDR_WIDTH; wrap from all-ones to 0 is legal and silent.
REQ-022 Copy is strictly ascending; overlapping ranges with dst>src are not corrected (forward-propagation is the defined result).
REQ-023 start while busy is ignored; no queuing.
REQ-024 In IDLE and DONE: mem_write=0, mem_address=0, mem_wdata=0.
REQ-025 mem_write is decoded from the state register only (no combinational path from start).

Reset
REQ-026 rst=1 at a posedge forces IDLE regardless of state, including mid-transfer; no further writes after that edge.
REQ-027 Reset values: busy=0, done=0, mem_write=0, mem_address=0, mem_wdata=0, pointers, count and buffer=0.
REQ-028 A transfer interrupted by reset is not resumed and produces no done pulse.

Configuration
REQ-029 Macro MEM_COPY_FILL_EN, when defined, adds inputs fill (1 bit) and fill_value (DATA_WIDTH), sampled with start.
REQ-030 With MEM_COPY_FILL_EN and fill=1: FSM skips READ, writes fill_value to dst..dst+N-1, one word per cycle; done exactly N+1 cycles after start-accept; src_addr ignored.
REQ-031 Without MEM_COPY_FILL_EN: ports absent, copy-only behaviour per REQ-016..REQ-025.

Structure
REQ-032 Package mem_copy_pkg holds the state typedef (IDLE, READ, WRITE, DONE) and default width constants.
REQ-033 Single module, no sub-module; the RAM is instantiated only in the testbench.

Verification
REQ-034 Preload RAM[i]=i+0x100; start src=0, dst=0x200, length=4 -> RAM[0x200..0x203]=0x100..0x103, done at cycle 9, 4 write cycles.
REQ-035 start with length=0 -> done at cycle 1, mem_write never asserted, RAM unchanged.
REQ-036 src=0x3FE, dst=0x010, length=4 -> reads 0x3FE,0x3FF,0x000,0x001 wrap correctly into 0x010..0x013.
REQ-037 rst asserted during 3rd WRITE of a length=8 copy -> exactly 2 words written, no done, busy=0 after the edge.
REQ-038 start pulsed again while busy -> ignored; single done pulse for the first transfer.
REQ-039 MEM_COPY_FILL_EN defined: fill=1, fill_value=0xDEADBEEF, dst=0x050, length=3 -> RAM[0x050..0x052]=0xDEADBEEF, done at cycle 4.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the word-at-a-time memory copy engine.
package mem_copy_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Copies (or, with MEM_COPY_FILL_EN defined, fills) a block of RAM words one word
// per READ/WRITE pair; all outputs are registered from the next-state decode.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
`ifdef MEM_COPY_FILL_EN
    input  logic                  fill,
    input  logic [DATA_WIDTH-1:0] fill_value,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   src_ptr_r, src_ptr_s;
    logic [ADDR_WIDTH-1:0]   dst_ptr_r, dst_ptr_s;
    logic [ADDR_WIDTH:0]     count_r, count_s;
    logic [DATA_WIDTH-1:0]   buf_r, buf_s;
    logic                    fill_mode_s;
    logic                    fill_start_s;
    logic [ADDR_WIDTH-1:0]   address_s;
    logic [DATA_WIDTH-1:0]   wdata_s;
    logic                    busy_r, done_r, mem_write_r;
    logic [ADDR_WIDTH-1:0]   mem_address_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r;

`ifdef MEM_COPY_FILL_EN
    logic fill_r, fill_s;
    assign fill_mode_s  = fill_r;
    assign fill_start_s = fill;
`else
    assign fill_mode_s  = 1'b0;
    assign fill_start_s = 1'b0;
`endif

    // Next-state, pointer, count and buffer decode.
    always_comb begin
        state_s   = state_r;
        src_ptr_s = src_ptr_r;
        dst_ptr_s = dst_ptr_r;
        count_s   = count_r;
        buf_s     = buf_r;
`ifdef MEM_COPY_FILL_EN
        fill_s    = fill_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (length == CNT_ZERO) begin
                        state_s = DONE;
                    end else begin
                        src_ptr_s = src_addr;
                        dst_ptr_s = dst_addr;
                        count_s   = length;
`ifdef MEM_COPY_FILL_EN
                        fill_s    = fill;
                        buf_s     = fill ? fill_value : buf_r;
`endif
                        state_s   = fill_start_s ? WRITE : READ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                buf_s   = mem_rdata;
                state_s = WRITE;
            end
            WRITE: begin
                src_ptr_s = src_ptr_r + ADDR_ONE;
                dst_ptr_s = dst_ptr_r + ADDR_ONE;
                count_s   = count_r - CNT_ONE;
                if (count_r > CNT_ONE) begin
                    state_s = fill_mode_s ? WRITE : READ;
                end else begin
                    state_s = DONE;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // RAM-side values for the state being entered, so the port registers match it.
    always_comb begin
        address_s = ADDR_ZERO;
        wdata_s   = DATA_ZERO;
        case (state_s)
            READ: begin
                address_s = src_ptr_s;
            end
            WRITE: begin
                address_s = dst_ptr_s;
                wdata_s   = buf_s;
            end
            default: begin
                address_s = ADDR_ZERO;
                wdata_s   = DATA_ZERO;
            end
        endcase
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            src_ptr_r     <= ADDR_ZERO;
            dst_ptr_r     <= ADDR_ZERO;
            count_r       <= CNT_ZERO;
            buf_r         <= DATA_ZERO;
`ifdef MEM_COPY_FILL_EN
            fill_r        <= 1'b0;
`endif
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_address_r <= ADDR_ZERO;
            mem_wdata_r   <= DATA_ZERO;
        end else begin
            state_r       <= state_s;
            src_ptr_r     <= src_ptr_s;
            dst_ptr_r     <= dst_ptr_s;
            count_r       <= count_s;
            buf_r         <= buf_s;
`ifdef MEM_COPY_FILL_EN
            fill_r        <= fill_s;
`endif
            busy_r        <= (state_s != IDLE);
            done_r        <= (state_s == DONE);
            mem_write_r   <= (state_s == WRITE);
            mem_address_r <= address_s;
            mem_wdata_r   <= wdata_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign mem_write   = mem_write_r;
    assign mem_address = mem_address_r;
    assign mem_wdata   = mem_wdata_r;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a behavioural RAM.
module tb_mem_copy_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  src_addr;
    logic [9:0]  dst_addr;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic [9:0]  mem_address;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic [31:0] mem_rdata;
`ifdef MEM_COPY_FILL_EN
    logic        fill;
    logic [31:0] fill_value;
`endif

    logic [31:0] ram [0:1023];
    int          write_cnt;
    int          done_cnt;
    int          n_vectors;
    int          n_miscompares;
    int          done_cyc;
    int          writes;
    int          w0;
    int          d0;

    mem_copy_engine dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .length      (length),
`ifdef MEM_COPY_FILL_EN
        .fill        (fill),
        .fill_value  (fill_value),
`endif
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read RAM; a write coinciding with reset is cancelled.
    assign mem_rdata = ram[mem_address];
    always @(posedge clk) begin
        if (mem_write && !rst) begin
            ram[mem_address] <= mem_wdata;
            write_cnt <= write_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issue one start, optionally re-pulse start at cycle 'repulse', wait for done.
    task automatic run_copy(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n,
                            input int repulse, output int dcyc, output int nwr);
        int base;
        base = write_cnt;
        dcyc = 0;
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; length = n;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (cyc == 1) check_val("busy_after_accept", {31'd0, busy}, 32'd1);
            if (cyc == repulse) begin
                start = 1'b1; src_addr = 10'h000; dst_addr = 10'h300; length = 11'd2;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dcyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;
        check_val("done_one_cycle", {31'd0, done}, 32'd0);
        check_val("busy_cleared", {31'd0, busy}, 32'd0);
        nwr = write_cnt - base;
    endtask

    initial begin
        n_vectors = 0; n_miscompares = 0; write_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h100 + i;
        rst = 1'b1; start = 1'b0; src_addr = 10'h000; dst_addr = 10'h000; length = 11'd0;
`ifdef MEM_COPY_FILL_EN
        fill = 1'b0; fill_value = 32'h0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check_val("rst_mem_address", {22'd0, mem_address}, 32'd0);
        check_val("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // Basic copy 0x000 -> 0x200, 4 words.
        run_copy(10'h000, 10'h200, 11'd4, 0, done_cyc, writes);
        check_val("copy4_done_cycle", done_cyc, 32'd9);
        check_val("copy4_writes", writes, 32'd4);
        for (int i = 0; i < 4; i++) check_val("copy4_data", ram[10'h200 + i], 32'h100 + i);
        check_val("copy4_past_end", ram[10'h204], 32'h304);

        // Zero length: done next cycle, nothing written.
        run_copy(10'h000, 10'h300, 11'd0, 0, done_cyc, writes);
        check_val("len0_done_cycle", done_cyc, 32'd1);
        check_val("len0_writes", writes, 32'd0);
        check_val("len0_ram", ram[10'h300], 32'h400);

        // Source pointer wraps from 0x3FF to 0x000.
        run_copy(10'h3FE, 10'h010, 11'd4, 0, done_cyc, writes);
        check_val("wrap_done_cycle", done_cyc, 32'd9);
        check_val("wrap_w0", ram[10'h010], 32'h4FE);
        check_val("wrap_w1", ram[10'h011], 32'h4FF);
        check_val("wrap_w2", ram[10'h012], 32'h100);
        check_val("wrap_w3", ram[10'h013], 32'h101);

        // Second start while busy must be ignored.
        d0 = done_cnt;
        run_copy(10'h040, 10'h240, 11'd3, 3, done_cyc, writes);
        repeat (6) @(posedge clk);
        #1;
        check_val("busy_start_done_cycle", done_cyc, 32'd7);
        check_val("busy_start_done_pulses", done_cnt - d0, 32'd1);
        check_val("busy_start_writes", writes, 32'd3);
        check_val("busy_start_ram300", ram[10'h300], 32'h400);
        check_val("busy_start_data", ram[10'h242], 32'h142);

        // Reset during the third WRITE of an 8-word copy.
        w0 = write_cnt; d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; src_addr = 10'h020; dst_addr = 10'h220; length = 11'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("rst_mid_in_write", {31'd0, mem_write}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_val("rst_mid_mem_write", {31'd0, mem_write}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check_val("rst_mid_writes", write_cnt - w0, 32'd2);
        check_val("rst_mid_no_done", done_cnt - d0, 32'd0);
        check_val("rst_mid_w0", ram[10'h220], 32'h120);
        check_val("rst_mid_w1", ram[10'h221], 32'h121);
        check_val("rst_mid_w2", ram[10'h222], 32'h322);

`ifdef MEM_COPY_FILL_EN
        // Fill mode: no reads, one word per cycle.
        fill = 1'b1; fill_value = 32'hDEADBEEF;
        run_copy(10'h3AB, 10'h050, 11'd3, 0, done_cyc, writes);
        fill = 1'b0;
        check_val("fill_done_cycle", done_cyc, 32'd4);
        check_val("fill_writes", writes, 32'd3);
        for (int i = 0; i < 3; i++) check_val("fill_data", ram[10'h050 + i], 32'hDEADBEEF);
        check_val("fill_past_end", ram[10'h053], 32'h153);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
